// File: rtl/spi_master_ctrl.sv
// SPI master transfer sequencer: one command in, one full-duplex MSB-first transfer on the pins,
// one response out. Supports all four CPOL/CPHA modes and a programmable sclk divider.
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8,
  localparam int LW        = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_cpol_i,
  input  logic                  cfg_cpha_i,
  input  logic [DIV_WIDTH-1:0]  cfg_div_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  input  logic [LW-1:0]         cmd_len_i,
  input  logic                  cmd_vld_i,
  output logic                  cmd_rdy_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_vld_o,
  input  logic                  rsp_rdy_i,
  output logic                  busy_o,
  output logic                  sclk_o,
  output logic                  cs_n_o,
  output logic                  mosi_o,
  input  logic                  miso_i
);

  // Both ports use valid/ready: a beat transfers on the clk_i edge where valid && ready are both
  // high; valid, once raised, holds its payload stable until that edge.

  localparam int EW = LW + 2;  // sclk edge counter must reach 2*DATA_WIDTH

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, RESP} state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [LW-1:0]         len_q, len_d;
  logic                  cpha_q, cpha_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic                  busy_q, busy_d;
  logic                  cmd_rdy_q, cmd_rdy_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;

  logic                  tick;
  logic [EW-1:0]         edge_k;
  logic [EW-1:0]         two_n;
  logic                  capture;
  logic                  advance;

  assign tick    = (cnt_q == div_q);
  assign edge_k  = edge_q + 1'b1;
  assign two_n   = {1'b0, len_q, 1'b0} + EW'(2);
  // Odd edges are leading; cpha selects whether the leading or trailing edge samples.
  assign capture = edge_k[0] ^ cpha_q;
  assign advance = (edge_k[0] == cpha_q) && (edge_k != EW'(1)) && (edge_k != two_n);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    edge_d     = edge_q;
    len_d      = len_q;
    cpha_d     = cpha_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rsp_data_d = rsp_data_q;
    rsp_vld_d  = rsp_vld_q;
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    case (state_q)
      IDLE: begin
        sclk_d = cfg_cpol_i;
        cs_n_d = 1'b1;
        tx_d   = '0;
        if (cmd_vld_i && cmd_rdy_q) begin
          len_d   = cmd_len_i;
          cpha_d  = cfg_cpha_i;
          div_d   = cfg_div_i;
          cnt_d   = '0;
          edge_d  = '0;
          rx_d    = '0;
          // Left-align so bit N-1 sits in the MSB, which drives mosi_o directly.
          tx_d    = cmd_data_i << ~cmd_len_i;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_k;
          if (capture) rx_d = {rx_q[DATA_WIDTH-2:0], miso_i};
          if (advance) tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
          if (edge_k == two_n) state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          cnt_d      = '0;
          tx_d       = '0;
          cs_n_d     = 1'b1;
          rsp_vld_d  = 1'b1;
          rsp_data_d = rx_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_rdy_i) begin
          rsp_vld_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_rdy_d = (state_d == IDLE) && !rsp_vld_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      edge_q     <= '0;
      len_q      <= '0;
      cpha_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      rsp_data_q <= '0;
      rsp_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      cmd_rdy_q  <= 1'b1;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      len_q      <= len_d;
      cpha_q     <= cpha_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rsp_data_q <= rsp_data_d;
      rsp_vld_q  <= rsp_vld_d;
      busy_q     <= busy_d;
      cmd_rdy_q  <= cmd_rdy_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign cmd_rdy_o  = cmd_rdy_q;
  assign rsp_data_o = rsp_data_q;
  assign rsp_vld_o  = rsp_vld_q;
  assign busy_o     = busy_q;
  assign sclk_o     = sclk_q;
  assign cs_n_o     = cs_n_q;
  assign mosi_o     = tx_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: directed scenarios plus random transfers, checked every cycle
// against a timing-formula model of the SPI frame.
module tb_spi_master_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        cfg_cpol = 1'b0;
  logic        cfg_cpha = 1'b0;
  logic [7:0]  cfg_div  = 8'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [4:0]  cmd_len  = 5'd0;
  logic        cmd_vld  = 1'b0;
  logic        rsp_rdy  = 1'b0;
  logic        miso     = 1'b0;
  logic        cmd_rdy_o, rsp_vld_o, busy_o, sclk_o, cs_n_o, mosi_o;
  logic [31:0] rsp_data_o;

  spi_master_ctrl dut (
    .clk_i(clk), .rst_i(rst), .cfg_cpol_i(cfg_cpol), .cfg_cpha_i(cfg_cpha), .cfg_div_i(cfg_div),
    .cmd_data_i(cmd_data), .cmd_len_i(cmd_len), .cmd_vld_i(cmd_vld), .cmd_rdy_o(cmd_rdy_o),
    .rsp_data_o(rsp_data_o), .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy), .busy_o(busy_o),
    .sclk_o(sclk_o), .cs_n_o(cs_n_o), .mosi_o(mosi_o), .miso_i(miso)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transfer timeline: accept at cycle t0, sclk edge k at t0+k*P (P=div+1), cs_n rises at t0+(2N+1)*P.
  int          cyc = 0, mode = 0, t0 = 0, m_n = 1, m_p = 1, m_caps = 0, n_acc = 0;
  int          mj, me, madv, midx;
  logic        m_cpha = 1'b0, m_cpol = 1'b0, m_live = 1'b0, chk_zero = 1'b0;
  logic [31:0] m_data = 32'd0, m_rx = 32'd0, e_rsp = 32'd0;
  logic        e_cs = 1'b1, e_sclk = 1'b0, e_mosi = 1'b0, e_busy = 1'b0, e_rdy = 1'b1, e_vld = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mode = 0; e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0;
      e_rdy = 1'b1; e_vld = 1'b0; chk_zero = 1'b1; m_live = 1'b1;
    end else begin
      case (mode)
        0: begin
          e_sclk = cfg_cpol;
          if (cmd_vld && e_rdy) begin
            m_n = int'(cmd_len) + 1; m_p = int'(cfg_div) + 1; m_cpha = cfg_cpha; m_cpol = cfg_cpol;
            m_data = cmd_data; m_rx = 32'd0; m_caps = 0; t0 = cyc; mode = 1; n_acc++;
          end
        end
        1: begin
          mj = cyc - t0;
          if ((mj % m_p) == 0 && (mj / m_p) <= 2 * m_n) begin
            if ((((mj / m_p) % 2) == 1) != m_cpha) begin
              m_rx = {m_rx[30:0], miso};
              m_caps++;
            end
          end
          if (mj == (2 * m_n + 1) * m_p) begin
            mode = 2; e_rsp = m_rx; chk_zero = 1'b0;
          end
        end
        default: if (rsp_rdy) mode = 0;
      endcase
      if (mode == 1) begin
        mj = cyc - t0;
        me = (mj / m_p > 2 * m_n) ? 2 * m_n : mj / m_p;
        e_sclk = m_cpol ^ me[0];
        e_cs = 1'b0;
        if (!m_cpha) madv = me / 2;
        else madv = (me == 0) ? 0 : (me - 1) / 2;
        midx = m_n - 1 - madv;
        if (midx < 0) midx = 0;
        e_mosi = m_data[midx];
      end else begin
        e_cs = 1'b1; e_mosi = 1'b0;
      end
      e_busy = (mode != 0);
      e_vld  = (mode == 2);
      e_rdy  = (mode == 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      chk("pins{sclk,cs_n,mosi,busy,cmd_rdy,rsp_vld}",
          {26'd0, sclk_o, cs_n_o, mosi_o, busy_o, cmd_rdy_o, rsp_vld_o},
          {26'd0, e_sclk, e_cs, e_mosi, e_busy, e_rdy, e_vld});
      if (e_vld) chk("rsp_data", rsp_data_o, e_rsp);
      else if (chk_zero) chk("rsp_data_reset", rsp_data_o, 32'd0);
    end
  end

  // ---------------- miso slave driver (changes only on negedge) ----------------
  localparam int M_RAND = 0, M_LOOP = 1, M_PAT = 2, M_ONE = 3;
  int          miso_mode = M_RAND;
  logic [31:0] miso_pat  = 32'd0;
  always @(negedge clk) begin
    case (miso_mode)
      M_LOOP:  miso = mosi_o;
      M_PAT:   miso = (m_n - 1 - m_caps >= 0) ? miso_pat[m_n - 1 - m_caps] : 1'b0;
      M_ONE:   miso = 1'b1;
      default: miso = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- pin monitor ----------------
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, cur_cpha = 1'b0;
  int          cs_cnt = 0, rises = 0, edge_no = 0, n_falls = 0, last_cs = 0, last_rises = 0;
  logic [31:0] stream = 32'd0, last_stream = 32'd0, last_rsp = 32'd0;
  always @(negedge clk) begin
    if (!cs_n_o && prev_cs) begin
      cs_cnt = 0; rises = 0; edge_no = 0; stream = 32'd0; n_falls++;
    end
    if (!cs_n_o) begin
      cs_cnt++;
      if (!prev_cs && sclk_o != prev_sclk) begin
        edge_no++;
        if (sclk_o && !prev_sclk) rises++;
        if (((edge_no % 2) == 1) != cur_cpha) stream = {stream[30:0], mosi_o};
      end
    end
    if (cs_n_o && !prev_cs) begin
      last_cs = cs_cnt; last_rises = rises; last_stream = stream;
    end
    prev_cs = cs_n_o; prev_sclk = sclk_o;
  end

  // ---------------- driver (called and returns at a negedge) ----------------
  task automatic xfer(input logic cpol, input logic cpha, input logic [7:0] div, input logic [4:0] len,
                      input logic [31:0] data, input int mm, input logic [31:0] pat, input int rdly,
                      input int toggle_cyc, input int rst_cyc, input logic hold_vld);
    int acc0;
    bit got;
    acc0 = n_acc;
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_div = div; cur_cpha = cpha;
    cmd_data = data; cmd_len = len; cmd_vld = 1'b1; miso_mode = mm; miso_pat = pat;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (n_acc != acc0) got = 1'b1;
    end
    chk("accept_within_bound", {31'd0, got}, 32'd1);
    if (!got) begin cmd_vld = 1'b0; return; end
    if (!hold_vld) begin cmd_vld = 1'b0; cmd_data = $urandom; cmd_len = 5'($urandom); end
    if (toggle_cyc > 0) begin
      repeat (toggle_cyc - 1) @(negedge clk);
      cfg_cpol = ~cfg_cpol; cfg_div = div + 8'd3; cfg_cpha = ~cfg_cpha;
    end
    if (rst_cyc > 0) begin
      repeat (rst_cyc - 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_state{cs_n,sclk,busy,rsp_vld}", {28'd0, cs_n_o, sclk_o, busy_o, rsp_vld_o}, 32'h8);
      rst = 1'b0;
      return;
    end
    got = 1'b0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      if (rsp_vld_o) got = 1'b1;
    end
    chk("response_within_bound", {31'd0, got}, 32'd1);
    last_rsp = rsp_data_o;
    repeat (rdly) @(negedge clk);
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int f0;
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state{cs_n,sclk,mosi,busy,rsp_vld}",
        {27'd0, cs_n_o, sclk_o, mosi_o, busy_o, rsp_vld_o}, 32'h10);
    rst = 1'b0;
    @(negedge clk);

    // mode 0 loopback byte
    xfer(1'b0, 1'b0, 8'd0, 5'd7, 32'hA5, M_LOOP, 32'd0, 0, 0, 0, 1'b0);
    chk("t1_rsp", last_rsp, 32'h0000_00A5);
    chk("t1_cs_low", last_cs, 32'd17);
    chk("t1_rises", last_rises, 32'd8);
    chk("t1_idle_sclk", {31'd0, sclk_o}, 32'd0);

    // mode 3, full width, slave pattern
    xfer(1'b1, 1'b1, 8'd3, 5'd31, 32'hDEAD_BEEF, M_PAT, 32'h1234_5678, 0, 0, 0, 1'b0);
    chk("t2_rsp", last_rsp, 32'h1234_5678);
    chk("t2_mosi_stream", last_stream, 32'hDEAD_BEEF);
    chk("t2_cs_low", last_cs, 32'd260);
    @(negedge clk);
    chk("t2_idle_sclk", {31'd0, sclk_o}, 32'd1);

    // response back-pressure with a second command waiting
    f0 = n_falls;
    xfer(1'b0, 1'b0, 8'd1, 5'd3, 32'h9, M_RAND, 32'd0, 20, 0, 0, 1'b1);
    chk("t3_no_second_fall", n_falls - f0, 32'd1);
    xfer(1'b0, 1'b0, 8'd1, 5'd3, 32'h9, M_RAND, 32'd0, 0, 0, 0, 1'b0);
    chk("t3_second_fall", n_falls - f0, 32'd2);

    // config changes at edge 5 must not disturb the frame
    xfer(1'b0, 1'b1, 8'd1, 5'd15, 32'h0000_BEEF, M_RAND, 32'd0, 1, 5 * 2, 0, 1'b0);
    chk("t4_cs_low", last_cs, 32'd66);
    chk("t4_mosi_stream", last_stream, 32'h0000_BEEF);

    // reset at edge 6, then a clean transfer
    xfer(1'b0, 1'b0, 8'd2, 5'd15, 32'h0000_F00D, M_RAND, 32'd0, 0, 0, 6 * 3, 1'b0);
    xfer(1'b0, 1'b0, 8'd0, 5'd7, 32'h3C, M_LOOP, 32'd0, 0, 0, 0, 1'b0);
    chk("t5_rsp_after_reset", last_rsp, 32'h0000_003C);

    // single bit transfer
    xfer(1'b0, 1'b0, 8'd2, 5'd0, 32'h1, M_ONE, 32'd0, 0, 0, 0, 1'b0);
    chk("t6_rsp", last_rsp, 32'h0000_0001);
    chk("t6_cs_low", last_cs, 32'd9);
    chk("t6_rises", last_rises, 32'd1);

    // random transfers
    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)),
           5'($urandom_range(0, 31)), $urandom, M_RAND, 32'd0, $urandom_range(0, 4), 0, 0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
